// File: rtl/uart_tx_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_seq_ctrl
// Brief    : Sequences two BRAM read passes (channel 1, then channel 2) and
//            serialises each 24-bit {a,b} sample pair into three bytes for a
//            byte-level UART transmitter using a valid/ready handshake.
//            Optional macro UART_FRAME_HEADER_EN prefixes each channel pass
//            with the header bytes EB 90 <channel id>.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_seq_ctrl #(
  parameter int WORDS_PER_CH = 16384,
  parameter int RD_LAT       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        qpsk_signal_wr_over,
  input  logic [11:0] qpsk_signal_out_a,
  input  logic [11:0] qpsk_signal_out_b,
  output logic        uart_tx_start_1,
  output logic        uart_tx_start_2,
  output logic        uart_tx_24_done,
  output logic [7:0]  tx_byte,
  output logic        tx_byte_valid,
  input  logic        tx_byte_ready,
  output logic        tx_busy,
  output logic        tx_all_done
);

  localparam int CNT_W = $clog2(WORDS_PER_CH) + 1;
  localparam int LAT_W = $clog2(RD_LAT + 2);

  localparam logic [CNT_W-1:0] c_words   = CNT_W'(WORDS_PER_CH);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [LAT_W-1:0] c_rd_lat  = LAT_W'(RD_LAT);
  localparam logic [LAT_W-1:0] c_lat_one = LAT_W'(1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START_CH  = 4'd1,
    S_WAIT_RD   = 4'd2,
    S_SEND_B0   = 4'd3,
    S_SEND_B1   = 4'd4,
    S_SEND_B2   = 4'd5,
    S_WORD_DONE = 4'd6,
    S_CH_DONE   = 4'd7,
    S_ALL_DONE  = 4'd8
`ifdef UART_FRAME_HEADER_EN
    ,
    S_HDR0      = 4'd9,
    S_HDR1      = 4'd10,
    S_HDR2      = 4'd11
`endif
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_wr_over_q;
  logic               r_ch;          // 0: channel 1 pass, 1: channel 2 pass
  logic [CNT_W-1:0]   r_word_cnt;
  logic [LAT_W-1:0]   r_lat_cnt;     // cycles since the last read-address change
  logic [23:0]        r_shift;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_trig;
  logic               w_lat_ok;
  logic               w_in_pass;

  assign w_cnt_inc = r_word_cnt + c_cnt_one;
  assign w_trig    = qpsk_signal_wr_over & ~r_wr_over_q;
  assign w_lat_ok  = (r_lat_cnt >= c_rd_lat);

  assign uart_tx_start_1 = w_in_pass & ~r_ch;
  assign uart_tx_start_2 = w_in_pass &  r_ch;
  assign tx_busy         = (r_state != S_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and Moore/handshake outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_in_pass       = 1'b0;
    tx_byte_valid   = 1'b0;
    tx_byte         = 8'h00;
    uart_tx_24_done = 1'b0;
    tx_all_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trig) w_state_nxt = S_START_CH;
      end
      S_START_CH: begin
        w_in_pass = 1'b1;
`ifdef UART_FRAME_HEADER_EN
        w_state_nxt = S_HDR0;
`else
        w_state_nxt = S_WAIT_RD;
`endif
      end
`ifdef UART_FRAME_HEADER_EN
      S_HDR0: begin
        w_in_pass     = 1'b1;
        tx_byte_valid = 1'b1;
        tx_byte       = 8'hEB;
        if (tx_byte_ready) w_state_nxt = S_HDR1;
      end
      S_HDR1: begin
        w_in_pass     = 1'b1;
        tx_byte_valid = 1'b1;
        tx_byte       = 8'h90;
        if (tx_byte_ready) w_state_nxt = S_HDR2;
      end
      S_HDR2: begin
        w_in_pass     = 1'b1;
        tx_byte_valid = 1'b1;
        tx_byte       = r_ch ? 8'h02 : 8'h01;
        if (tx_byte_ready) w_state_nxt = S_WAIT_RD;
      end
`endif
      S_WAIT_RD: begin
        w_in_pass = 1'b1;
        if (w_lat_ok) w_state_nxt = S_SEND_B0;
      end
      S_SEND_B0: begin
        w_in_pass     = 1'b1;
        tx_byte_valid = 1'b1;
        tx_byte       = r_shift[23:16];
        if (tx_byte_ready) w_state_nxt = S_SEND_B1;
      end
      S_SEND_B1: begin
        w_in_pass     = 1'b1;
        tx_byte_valid = 1'b1;
        tx_byte       = r_shift[23:16];
        if (tx_byte_ready) w_state_nxt = S_SEND_B2;
      end
      S_SEND_B2: begin
        w_in_pass     = 1'b1;
        tx_byte_valid = 1'b1;
        tx_byte       = r_shift[23:16];
        if (tx_byte_ready) w_state_nxt = S_WORD_DONE;
      end
      S_WORD_DONE: begin
        w_in_pass       = 1'b1;
        uart_tx_24_done = 1'b1;
        if (w_cnt_inc >= c_words) w_state_nxt = S_CH_DONE;
        else                      w_state_nxt = S_WAIT_RD;
      end
      S_CH_DONE: begin
        if (r_ch) w_state_nxt = S_ALL_DONE;
        else      w_state_nxt = S_START_CH;
      end
      S_ALL_DONE: begin
        tx_all_done = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Trigger edge register, channel select, word/latency counters, data shifter
  always_ff @(posedge clk) begin
    if (rst) begin
      // Held at 1 so a wr_over level still high after reset is not taken as an edge
      r_wr_over_q <= 1'b1;
      r_ch        <= 1'b0;
      r_word_cnt  <= '0;
      r_lat_cnt   <= '0;
      r_shift     <= '0;
    end else begin
      r_wr_over_q <= qpsk_signal_wr_over;
      case (r_state)
        S_IDLE: begin
          r_ch <= 1'b0;
        end
        S_START_CH: begin
          r_word_cnt <= '0;
          r_lat_cnt  <= c_lat_one;
        end
        S_WORD_DONE: begin
          r_word_cnt <= w_cnt_inc;
          r_lat_cnt  <= c_lat_one;
        end
        S_CH_DONE: begin
          r_ch <= 1'b1;
        end
        default: begin
          // Saturating count; keeps running through header states so the
          // read latency overlaps header transmission
          if (r_lat_cnt < c_rd_lat) r_lat_cnt <= r_lat_cnt + c_lat_one;
        end
      endcase
      if (r_state == S_WAIT_RD && w_lat_ok)
        r_shift <= {qpsk_signal_out_a, qpsk_signal_out_b};
      else if ((r_state == S_SEND_B0 || r_state == S_SEND_B1) && tx_byte_ready)
        r_shift <= {r_shift[15:0], 8'h00};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_seq_ctrl
// Brief    : Directed self-checking bench for uart_tx_seq_ctrl with a small
//            BRAM read-port model (address reset on start rise, advance on
//            uart_tx_24_done, data valid RD_LAT cycles after the change).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_seq_ctrl;

  localparam int WORDS = 4;
  localparam int LAT   = 2;
`ifdef UART_FRAME_HEADER_EN
  localparam int HDR_N = 3;
`else
  localparam int HDR_N = 0;
`endif
  localparam int N_PER_CH = 3 * WORDS + HDR_N;
  localparam int N_EXP    = 2 * N_PER_CH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_over = 1'b0;
  logic        ready = 1'b0;
  logic [11:0] out_a, out_b;
  logic        start_1, start_2, done24, valid, busy, all_done;
  logic [7:0]  tx_byte;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_seq_ctrl #(.WORDS_PER_CH(WORDS), .RD_LAT(LAT)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .qpsk_signal_wr_over (wr_over),
    .qpsk_signal_out_a   (out_a),
    .qpsk_signal_out_b   (out_b),
    .uart_tx_start_1     (start_1),
    .uart_tx_start_2     (start_2),
    .uart_tx_24_done     (done24),
    .tx_byte             (tx_byte),
    .tx_byte_valid       (valid),
    .tx_byte_ready       (ready),
    .tx_busy             (busy),
    .tx_all_done         (all_done)
  );

  always #5 clk = ~clk;

  // Hand-computed byte stream: a[11:4], {a[3:0],b[11:8]}, b[7:0] per word
  logic [7:0] data_bytes [24] = '{
    8'hAB, 8'hC1, 8'h23,  8'h45, 8'h67, 8'h89,  8'hDE, 8'hF0, 8'h12,  8'h34, 8'h56, 8'h78,
    8'h5A, 8'h50, 8'hF0,  8'h11, 8'h12, 8'h22,  8'h33, 8'h34, 8'h44,  8'hFF, 8'hF0, 8'h00
  };
  logic [7:0] exp_q [$];
  int         exp_ch_q [$];

  function automatic logic [23:0] word_of(input int ch, input int idx);
    logic [23:0] w;
    w = 24'h000000;
    if (ch == 1) begin
      case (idx)
        0: w = 24'hABC123;
        1: w = 24'h456789;
        2: w = 24'hDEF012;
        3: w = 24'h345678;
        default: w = 24'h000000;
      endcase
    end else begin
      case (idx)
        0: w = 24'h5A50F0;
        1: w = 24'h111222;
        2: w = 24'h333444;
        3: w = 24'hFFF000;
        default: w = 24'h000000;
      endcase
    end
    return w;
  endfunction

  // BRAM read-port model
  logic        s1_q = 1'b0, s2_q = 1'b0;
  int          addr = 0;
  int          since = 0;
  bit          from_done = 1'b0;
  bit          strict = 1'b0;
  logic [23:0] mw;
  logic        mvalid;

  always @(posedge clk) begin
    s1_q <= start_1;
    s2_q <= start_2;
    if ((start_1 && !s1_q) || (start_2 && !s2_q)) begin
      addr <= 0; since <= 1; from_done <= 1'b0;
    end else if (done24) begin
      addr <= addr + 1; since <= 1; from_done <= 1'b1;
    end else if (since < 100) begin
      since <= since + 1;
    end
  end

  always_comb begin
    mw     = word_of(start_2 ? 2 : 1, addr & 3);
    mvalid = (since >= LAT) && !(strict && from_done && since > LAT);
    out_a  = mvalid ? mw[23:12] : ~mw[23:12];
    out_b  = mvalid ? mw[11:0]  : ~mw[11:0];
  end

  // Transfer monitor, sampled on the falling edge
  logic [7:0] got_q [$];
  int         got_ch_q [$];
  int         d1 = 0, d2 = 0, alld = 0, overlap = 0;

  always @(negedge clk) begin
    if (valid && ready) begin
      got_q.push_back(tx_byte);
      got_ch_q.push_back(start_2 ? 2 : (start_1 ? 1 : 0));
    end
    if (done24 && start_1) d1++;
    if (done24 && start_2) d2++;
    if (all_done) alld++;
    if (start_1 && start_2) overlap++;
  end

  task automatic pulse_trigger();
    @(posedge clk); #1 wr_over = 1'b1;
    @(posedge clk); #1 wr_over = 1'b0;
  endtask

  task automatic wait_all_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (all_done === 1'b1) begin ok = 1'b1; break; end
    end
    @(negedge clk); #1;
  endtask

  task automatic wait_byte(input logic [7:0] val, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (valid === 1'b1 && tx_byte === val) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_over = 1'b1; ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({start_1, start_2, done24, tx_byte, valid, busy, all_done} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {start_1, start_2, done24, tx_byte, valid, busy, all_done});
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_level_no_trigger: busy=%b, expected 0", busy);
    end
    @(posedge clk); #1 wr_over = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_basic();
    int base, b1, b2, ba, bo;
    bit ok;
    ready = 1'b1;
    base = got_q.size(); b1 = d1; b2 = d2; ba = alld; bo = overlap;
    pulse_trigger();
    wait_all_done(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL basic_timeout: all_done not seen, expected within budget"); end
    n_tests++;
    if (got_q.size() - base !== N_EXP) begin
      n_fail++; $display("FAIL basic_count: got %0d bytes, expected %0d", got_q.size() - base, N_EXP);
    end
    for (int i = 0; i < N_EXP; i++) begin
      n_tests++;
      if (base + i >= got_q.size()) begin
        n_fail++; $display("FAIL basic_byte[%0d]: got none, expected %02h", i, exp_q[i]);
      end else if (got_q[base+i] !== exp_q[i] || got_ch_q[base+i] !== exp_ch_q[i]) begin
        n_fail++; $display("FAIL basic_byte[%0d]: got %02h ch%0d, expected %02h ch%0d",
                           i, got_q[base+i], got_ch_q[base+i], exp_q[i], exp_ch_q[i]);
      end
    end
    n_tests++;
    if (d1 - b1 !== WORDS || d2 - b2 !== WORDS) begin
      n_fail++; $display("FAIL basic_done_pulses: got ch1=%0d ch2=%0d, expected %0d each", d1 - b1, d2 - b2, WORDS);
    end
    n_tests++;
    if (alld - ba !== 1) begin
      n_fail++; $display("FAIL basic_all_done: got %0d pulses, expected 1", alld - ba);
    end
    n_tests++;
    if (overlap !== bo) begin
      n_fail++; $display("FAIL basic_start_overlap: got %0d cycles, expected 0", overlap - bo);
    end
    n_tests++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle_after: busy=%b valid=%b, expected 0 0", busy, valid);
    end
  endtask

  task automatic test_backpressure();
    int base, hold_sz;
    bit ok;
    ready = 1'b1;
    base = got_q.size();
    pulse_trigger();
    wait_byte(8'hAB, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL bp_first_byte: AB not presented, expected it"); end
    @(posedge clk); #1 ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (valid !== 1'b1 || tx_byte !== 8'hC1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: valid=%b byte=%02h, expected 1 C1", i, valid, tx_byte);
      end
    end
    #1 hold_sz = got_q.size();
    n_tests++;
    if (hold_sz - base !== HDR_N + 1) begin
      n_fail++; $display("FAIL bp_no_transfer: got %0d bytes, expected %0d", hold_sz - base, HDR_N + 1);
    end
    @(posedge clk); #1 ready = 1'b1;
    wait_all_done(ok);
    n_tests++;
    if (!ok || got_q.size() - base !== N_EXP) begin
      n_fail++; $display("FAIL bp_count: got %0d bytes, expected %0d", got_q.size() - base, N_EXP);
    end
    for (int i = 0; i < N_EXP && base + i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[base+i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_byte[%0d]: got %02h, expected %02h", i, got_q[base+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_read_latency();
    int base;
    bit ok;
    ready = 1'b1;
    strict = 1'b1;
    base = got_q.size();
    pulse_trigger();
    wait_all_done(ok);
    strict = 1'b0;
    n_tests++;
    if (!ok || got_q.size() - base !== N_EXP) begin
      n_fail++; $display("FAIL lat_count: got %0d bytes, expected %0d", got_q.size() - base, N_EXP);
    end
    for (int i = 0; i < N_EXP && base + i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[base+i] !== exp_q[i]) begin
        n_fail++; $display("FAIL lat_byte[%0d]: got %02h, expected %02h", i, got_q[base+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_retrigger();
    int base, ba, sz;
    bit ok;
    ready = 1'b1;
    base = got_q.size(); ba = alld;
    pulse_trigger();
    repeat (10) @(posedge clk);
    pulse_trigger();
    wait_all_done(ok);
    n_tests++;
    if (!ok || got_q.size() - base !== N_EXP || alld - ba !== 1) begin
      n_fail++; $display("FAIL retrig_ignored: got %0d bytes %0d all_done, expected %0d and 1",
                         got_q.size() - base, alld - ba, N_EXP);
    end
    sz = got_q.size();
    repeat (20) @(negedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || got_q.size() !== sz) begin
      n_fail++; $display("FAIL retrig_not_queued: busy=%b extra bytes=%0d, expected 0 0", busy, got_q.size() - sz);
    end
    pulse_trigger();
    wait_all_done(ok);
    n_tests++;
    if (!ok || got_q.size() - sz !== N_EXP) begin
      n_fail++; $display("FAIL retrig_fresh_run: got %0d bytes, expected %0d", got_q.size() - sz, N_EXP);
    end
    for (int i = 0; i < N_EXP && sz + i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[sz+i] !== exp_q[i]) begin
        n_fail++; $display("FAIL retrig_byte[%0d]: got %02h, expected %02h", i, got_q[sz+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int sz, b1;
    bit ok;
    ready = 1'b1;
    pulse_trigger();
    wait_byte(8'h67, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rstmid_reach: byte 67 not presented, expected it"); end
    @(posedge clk); #1 rst = 1'b1; ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (valid !== 1'b1 || tx_byte !== 8'h89) begin
      n_fail++; $display("FAIL rstmid_in_b2: valid=%b byte=%02h, expected 1 89", valid, tx_byte);
    end
    #1 sz = got_q.size(); b1 = d1;
    @(negedge clk);
    n_tests++;
    if ({start_1, start_2, done24, tx_byte, valid, busy, all_done} !== 14'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %b, expected all zero",
                         {start_1, start_2, done24, tx_byte, valid, busy, all_done});
    end
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    n_tests++;
    if (got_q.size() !== sz || d1 !== b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_quiet: extra bytes=%0d extra done=%0d busy=%b, expected 0 0 0",
                         got_q.size() - sz, d1 - b1, busy);
    end
  endtask

  initial begin
    for (int ch = 1; ch <= 2; ch++) begin
`ifdef UART_FRAME_HEADER_EN
      exp_q.push_back(8'hEB); exp_ch_q.push_back(ch);
      exp_q.push_back(8'h90); exp_ch_q.push_back(ch);
      exp_q.push_back(ch == 1 ? 8'h01 : 8'h02); exp_ch_q.push_back(ch);
`endif
      for (int i = 0; i < 12; i++) begin
        exp_q.push_back(data_bytes[(ch - 1) * 12 + i]);
        exp_ch_q.push_back(ch);
      end
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_read_latency();
    test_retrigger();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
